// File: rtl/aes_round_sequencer.sv
// Round-sequencing controller for an iterative AES datapath: walks the key-schedule /
// SubBytes / ShiftRows / MixColumns / AddRoundKey steps for 10, 12 or 14 rounds.
module aes_round_sequencer #(
    parameter int KEY_BITS       = 128,
    parameter bit ENABLE_DECRYPT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       decrypt,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       inv,
    output logic [2:0] step,
    output logic [3:0] round,
    output logic       last_round,
    output logic       done
);

    localparam int         NR   = 6 + KEY_BITS / 32;
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE, S_ARK0, S_KEY, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       inv_q, inv_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       last_q, last_d;
    logic [2:0] step_q, step_d;

    function automatic logic [2:0] step_code(input state_t s);
        case (s)
            S_KEY:          return 3'd1;
            S_SUB:          return 3'd2;
            S_SHIFT:        return 3'd3;
            S_MIX:          return 3'd4;
            S_ARK0, S_ARK:  return 3'd5;
            S_DONE:         return 3'd6;
            default:        return 3'd0;
        endcase
    endfunction

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        inv_d   = inv_q;

        case (state_q)
            S_IDLE: begin
                round_d = 4'd0;
                if (start) begin
                    inv_d   = decrypt & ENABLE_DECRYPT;
                    round_d = (decrypt & ENABLE_DECRYPT) ? NR_L : 4'd0;
                    state_d = S_ARK0;
                end
            end
            S_ARK0:  state_d = S_KEY;
            S_KEY:   state_d = inv_q ? S_SHIFT : S_SUB;
            S_SUB:   state_d = inv_q ? S_ARK : S_SHIFT;
            S_SHIFT: begin
                if (inv_q)                 state_d = S_SUB;
                else if (round_q == NR_L)  state_d = S_ARK;
                else                       state_d = S_MIX;
            end
            S_MIX:   state_d = inv_q ? S_KEY : S_ARK;
            S_ARK: begin
                if (inv_q) state_d = (round_q == 4'd0) ? S_DONE : S_MIX;
                else       state_d = (round_q == NR_L) ? S_DONE : S_KEY;
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
                inv_d   = 1'b0;
            end
        endcase

        // The round index moves only when KEY is entered; the exit conditions above keep it in 0..NR.
        if (state_d == S_KEY && state_q != S_KEY)
            round_d = inv_q ? round_q - 4'd1 : round_q + 4'd1;

        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_IDLE;
            round_d = 4'd0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        step_d  = step_code(state_d);
        last_d  = (state_d != S_IDLE) && (inv_d ? (round_d == 4'd0) : (round_d == NR_L));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            inv_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            inv_q   <= inv_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
            step_q  <= step_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign inv        = inv_q;
    assign step       = step_q;
    assign round      = round_q;
    assign last_round = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: three instances (128/enc+dec, 256/enc+dec, 192/enc-only)
// compared cycle by cycle against a step/round list built from the round rules.
module tb_aes_round_sequencer;

    logic       clk;
    logic       reset;
    logic       start      [3];
    logic       decrypt    [3];
    logic       abort      [3];
    logic       ready_o    [3];
    logic       busy_o     [3];
    logic       inv_o      [3];
    logic [2:0] step_o     [3];
    logic [3:0] round_o    [3];
    logic       last_o     [3];
    logic       done_o     [3];

    int n_tests = 0;
    int n_fail  = 0;

    int nr_tab [3] = '{10, 14, 12};
    bit en_tab [3] = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        logic [2:0] step;
        logic [3:0] rnd;
    } exp_t;

    exp_t exp_q[$];

    aes_round_sequencer #(.KEY_BITS(128), .ENABLE_DECRYPT(1'b1)) u_dut128 (
        .clk(clk), .reset(reset), .start(start[0]), .decrypt(decrypt[0]), .abort(abort[0]),
        .ready(ready_o[0]), .busy(busy_o[0]), .inv(inv_o[0]), .step(step_o[0]),
        .round(round_o[0]), .last_round(last_o[0]), .done(done_o[0])
    );

    aes_round_sequencer #(.KEY_BITS(256), .ENABLE_DECRYPT(1'b1)) u_dut256 (
        .clk(clk), .reset(reset), .start(start[1]), .decrypt(decrypt[1]), .abort(abort[1]),
        .ready(ready_o[1]), .busy(busy_o[1]), .inv(inv_o[1]), .step(step_o[1]),
        .round(round_o[1]), .last_round(last_o[1]), .done(done_o[1])
    );

    aes_round_sequencer #(.KEY_BITS(192), .ENABLE_DECRYPT(1'b0)) u_dut192 (
        .clk(clk), .reset(reset), .start(start[2]), .decrypt(decrypt[2]), .abort(abort[2]),
        .ready(ready_o[2]), .busy(busy_o[2]), .inv(inv_o[2]), .step(step_o[2]),
        .round(round_o[2]), .last_round(last_o[2]), .done(done_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected step/round list for one operation, straight from the round rules.
    task automatic build_seq(input int nr, input bit inv_mode);
        exp_q.delete();
        if (!inv_mode) begin
            exp_q.push_back('{3'd5, 4'd0});
            for (int r = 1; r <= nr; r++) begin
                exp_q.push_back('{3'd1, 4'(r)});
                exp_q.push_back('{3'd2, 4'(r)});
                exp_q.push_back('{3'd3, 4'(r)});
                if (r != nr) exp_q.push_back('{3'd4, 4'(r)});
                exp_q.push_back('{3'd5, 4'(r)});
            end
            exp_q.push_back('{3'd6, 4'(nr)});
        end else begin
            exp_q.push_back('{3'd5, 4'(nr)});
            for (int r = nr - 1; r >= 0; r--) begin
                exp_q.push_back('{3'd1, 4'(r)});
                exp_q.push_back('{3'd3, 4'(r)});
                exp_q.push_back('{3'd2, 4'(r)});
                exp_q.push_back('{3'd5, 4'(r)});
                if (r != 0) exp_q.push_back('{3'd4, 4'(r)});
            end
            exp_q.push_back('{3'd6, 4'd0});
        end
    endtask

    // {ready, busy, done, inv, last_round, step, round} implied by a step code and round.
    function automatic logic [11:0] exp_vec(input logic [2:0] s, input logic [3:0] r,
                                            input bit inv_mode, input int nr);
        logic last;
        last = (s != 3'd0) && (inv_mode ? (r == 4'd0) : (r == 4'(nr)));
        return {s == 3'd0, (s >= 3'd1 && s <= 3'd5), s == 3'd6, inv_mode, last, s, r};
    endfunction

    // Runs one operation on instance idx, starting and ending in IDLE at a falling edge.
    // abort_at: 0 = none, else the cycle (1 = ARK0) during which abort is raised.
    task automatic run_op(input string tag, input int idx, input bit dec_in, input int abort_at,
                          input bit chaos, input bit hold);
        int          nr;
        bit          m;
        int          first_done;
        bit          aborted;
        int          n_exp;
        logic [11:0] got, want;
        logic [8:0]  got_i, want_i;

        nr = nr_tab[idx];
        m  = dec_in & en_tab[idx];
        build_seq(nr, m);
        n_exp      = exp_q.size();
        first_done = -1;
        aborted    = 1'b0;

        start[idx]   = 1'b1;
        decrypt[idx] = dec_in;
        @(posedge clk);
        #1;
        start[idx] = hold;
        if (!hold) decrypt[idx] = 1'($urandom);

        for (int c = 1; c <= n_exp; c++) begin
            @(negedge clk);
            got  = {ready_o[idx], busy_o[idx], done_o[idx], inv_o[idx], last_o[idx],
                    step_o[idx], round_o[idx]};
            want = exp_vec(exp_q[c-1].step, exp_q[c-1].rnd, m, nr);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s seq cycle %0d: got rdy/bsy/dn/inv/last/step/rnd=%b want %b",
                         tag, c, got, want);
            end
            if (done_o[idx] === 1'b1 && first_done < 0) first_done = c;
            if (c == abort_at) begin
                abort[idx] = 1'b1;
                start[idx] = 1'b0;
                aborted    = 1'b1;
                break;
            end
            if (chaos && !hold) begin
                start[idx]   = (c == n_exp) ? 1'b0 : 1'($urandom);
                decrypt[idx] = 1'($urandom);
                if (c == n_exp) abort[idx] = 1'($urandom);
            end
        end

        if (aborted) begin
            @(negedge clk);
            abort[idx] = 1'b0;
            got_i  = {ready_o[idx], busy_o[idx], done_o[idx], last_o[idx], step_o[idx], round_o[idx]};
            want_i = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0};
            n_tests++;
            if (got_i !== want_i) begin
                n_fail++;
                $display("FAIL %s after abort: got rdy/bsy/dn/last/step/rnd=%b want %b", tag, got_i, want_i);
            end
            first_done = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done_o[idx] !== 1'b0 || ready_o[idx] !== 1'b1) first_done = 1;
            end
            n_tests++;
            if (first_done != 0) begin
                n_fail++;
                $display("FAIL %s post-abort quiet: done/ready disturbed, got flag %0d want 0", tag, first_done);
            end
        end else begin
            n_tests++;
            if (first_done != 5 * nr + 1) begin
                n_fail++;
                $display("FAIL %s latency: done at cycle %0d want %0d", tag, first_done, 5 * nr + 1);
            end
            @(negedge clk);
            abort[idx] = 1'b0;
            got_i  = {ready_o[idx], busy_o[idx], done_o[idx], last_o[idx], step_o[idx], 4'd0};
            want_i = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0};
            n_tests++;
            if (got_i !== want_i) begin
                n_fail++;
                $display("FAIL %s idle after done: got rdy/bsy/dn/last/step=%b want %b",
                         tag, got_i[8:4], want_i[8:4]);
            end
            if (hold) begin
                @(negedge clk);
                got_i  = {ready_o[idx], busy_o[idx], done_o[idx], last_o[idx], step_o[idx], round_o[idx]};
                want_i = {1'b0, 1'b1, 1'b0, 1'b0, 3'd5, m ? 4'(nr) : 4'd0};
                n_tests++;
                if (got_i !== want_i) begin
                    n_fail++;
                    $display("FAIL %s restart ARK0: got rdy/bsy/dn/last/step/rnd=%b want %b", tag, got_i, want_i);
                end
                start[idx] = 1'b0;
                abort[idx] = 1'b1;
                @(negedge clk);
                abort[idx] = 1'b0;
                n_tests++;
                if (ready_o[idx] !== 1'b1 || round_o[idx] !== 4'd0) begin
                    n_fail++;
                    $display("FAIL %s cleanup abort: got ready=%b round=%0d want ready=1 round=0",
                             tag, ready_o[idx], round_o[idx]);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [11:0] got;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; decrypt[i] = 1'b0; abort[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            got = {ready_o[i], busy_o[i], done_o[i], inv_o[i], last_o[i], step_o[i], round_o[i]};
            n_tests++;
            if (got !== 12'b1000_0000_0000) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %b want 100000000000", i, got);
            end
        end
        @(negedge clk);
        reset = 1'b0;

        // Encrypt on dut0 and decrypt on dut1, then reset asynchronously mid-round.
        @(negedge clk);
        start[0] = 1'b1; decrypt[0] = 1'b0;
        start[1] = 1'b1; decrypt[1] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            got = {ready_o[i], busy_o[i], done_o[i], inv_o[i], last_o[i], step_o[i], round_o[i]};
            n_tests++;
            if (got !== 12'b1000_0000_0000) begin
                n_fail++;
                $display("FAIL reset mid-round dut%0d: got %b want 100000000000", i, got);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt_128;
        run_op("enc128", 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_decrypt_256;
        run_op("dec256", 1, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_decrypt_disabled_192;
        run_op("nodec192", 2, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        run_op("abort30", 0, 1'b0, 30, 1'b0, 1'b0);
        run_op("after_abort", 0, 1'b0, 0, 1'b0, 1'b0);
        // abort together with start in IDLE: start wins.
        start[1] = 1'b1; abort[1] = 1'b1; decrypt[1] = 1'b0;
        @(negedge clk);
        start[1] = 1'b0; abort[1] = 1'b0;
        n_tests++;
        if (step_o[1] !== 3'd5 || busy_o[1] !== 1'b1 || round_o[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL start_vs_abort: got step=%0d busy=%b round=%0d want step=5 busy=1 round=0",
                     step_o[1], busy_o[1], round_o[1]);
        end
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        n_tests++;
        if (ready_o[1] !== 1'b1 || done_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_ark0: got ready=%b done=%b want ready=1 done=0", ready_o[1], done_o[1]);
        end
    endtask

    task automatic test_random;
        int idx, nr, ab;
        bit dec;
        for (int t = 0; t < 8; t++) begin
            idx = int'($urandom_range(2, 0));
            dec = 1'($urandom);
            nr  = nr_tab[idx];
            ab  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(5 * nr, 1)) : 0;
            run_op($sformatf("rand%0d", t), idx, dec, ab, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        run_op("b2b_enc128", 0, 1'b0, 0, 1'b0, 1'b1);
        run_op("b2b_dec256", 1, 1'b1, 0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_encrypt_128();
        test_decrypt_256();
        test_decrypt_disabled_192();
        test_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
